// File: rtl/host_cmd_sequencer.sv
// Queued WRITE/READ/WAIT/DELAY command master for the Top m0 port. WRITE takes 3 cycles with grant high, READ 2+RD_LAT.
// Backpressure: cmd_ready drops while the command FIFO is full; a freed slot is visible the cycle after a pop.

module hcs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module host_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        m0_req,
  output logic        m0_wr,
  output logic [15:0] m0_addr,
  output logic [31:0] m0_dout,
  input  logic        m0_grant,
  input  logic [31:0] m_din,
  input  logic        d_interrupt,
  input  logic        a_interrupt,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        err_clr
);
  localparam logic [2:0] OP_WRITE     = 3'd0;
  localparam logic [2:0] OP_READ      = 3'd1;
  localparam logic [2:0] OP_WAIT_DIRQ = 3'd2;
  localparam logic [2:0] OP_WAIT_AIRQ = 3'd3;
  localparam logic [2:0] OP_DELAY     = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WR, S_RD, S_WAIT_IRQ, S_DELAY, S_ERR} state_t;

  state_t      state, state_nxt;
  cmd_t        push_cmd, head, cur;
  logic        fifo_full, fifo_empty, pop;
  logic [15:0] tcnt;
  logic        last_bus;
  logic        timeout_hit, rd_done, delay_done, irq;
  logic        err_set;
  logic [1:0]  err_set_code;

  assign push_cmd = {cmd_op, cmd_addr, cmd_data};

  hcs_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (cmd_valid),
    .push_dat (push_cmd),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign busy        = (state != S_IDLE) || !fifo_empty;
  assign timeout_hit = (tcnt == 16'(TIMEOUT - 1));
  assign rd_done     = (tcnt == 16'(RD_LAT - 1));
  assign delay_done  = ({1'b0, tcnt} + 17'd1) >= {1'b0, cur.data[15:0]};
  assign irq         = (cur.op == OP_WAIT_AIRQ) ? a_interrupt : d_interrupt;

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_set_code = 2'b00;
    m0_req       = 1'b0;
    m0_wr        = 1'b0;
    m0_addr      = 16'hFFFF;
    m0_dout      = '0;
    case (state)
      S_IDLE: begin
        // Keep the bus between back-to-back bus commands so the DMAC cannot slip in.
        m0_req = last_bus && !fifo_empty && (head.op == OP_WRITE || head.op == OP_READ);
        if (!fifo_empty) begin
          case (head.op)
            OP_WRITE, OP_READ:          state_nxt = S_REQ;
            OP_WAIT_DIRQ, OP_WAIT_AIRQ: state_nxt = S_WAIT_IRQ;
            OP_DELAY:                   state_nxt = S_DELAY;
            default: begin
              state_nxt    = S_ERR;
              err_set      = 1'b1;
              err_set_code = 2'b11;
            end
          endcase
        end
      end
      S_REQ: begin
        m0_req  = 1'b1;
        m0_addr = cur.addr;
        if (m0_grant) begin
          state_nxt = (cur.op == OP_WRITE) ? S_WR : S_RD;
        end else if (timeout_hit) begin
          state_nxt    = S_ERR;
          err_set      = 1'b1;
          err_set_code = 2'b01;
        end
      end
      S_WR: begin
        m0_req    = 1'b1;
        m0_wr     = 1'b1;
        m0_addr   = cur.addr;
        m0_dout   = cur.data;
        state_nxt = S_IDLE;
      end
      S_RD: begin
        m0_req  = 1'b1;
        m0_addr = cur.addr;
        if (rd_done) state_nxt = S_IDLE;
      end
      S_WAIT_IRQ: begin
        if (irq) begin
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          state_nxt    = S_ERR;
          err_set      = 1'b1;
          err_set_code = 2'b10;
        end
      end
      S_DELAY: begin
        if (delay_done) state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cur      <= '0;
      tcnt     <= '0;
      last_bus <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      last_bus <= (state_nxt == S_IDLE) && (state == S_WR || state == S_RD);
      rd_valid <= (state == S_RD) && (state_nxt == S_IDLE);
      if (state == S_RD && state_nxt == S_IDLE) rd_data <= m_din;
      if (pop) cur <= head;
      if (state_nxt != state) tcnt <= '0;
      else if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_set_code;
      end else if (state == S_ERR && err_clr) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Bench for host_cmd_sequencer: directed timing scenarios plus a randomized command stream
// scored against a transaction-level memory model.

module tb_host_cmd_sequencer;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        m0_req, m0_wr;
  logic [15:0] m0_addr;
  logic [31:0] m0_dout;
  logic        m0_grant;
  logic [31:0] m_din;
  logic        d_interrupt, a_interrupt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy, err;
  logic [1:0]  err_code;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic        grant_dir = 1'b0;
  logic        rand_grant = 1'b0;
  logic [31:0] slave_mem [16];
  logic [47:0] wr_obs [$];
  logic [31:0] rd_obs [$];

  host_cmd_sequencer #(.DEPTH(8), .TIMEOUT(TO), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_grant(m0_grant), .m_din(m_din), .d_interrupt(d_interrupt), .a_interrupt(a_interrupt),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err), .err_code(err_code),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Bus slave: 16-word memory, read data registered one cycle after the address.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= (i == 5) ? 32'h1 : (32'hC0DE_0000 | 32'(i));
      m_din <= '0;
    end else begin
      m_din <= slave_mem[m0_addr[3:0]];
      if (m0_wr) slave_mem[m0_addr[3:0]] <= m0_dout;
    end
  end

  initial begin
    m0_grant = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m0_grant = rand_grant ? ($urandom_range(0, 3) != 0) : grant_dir;
    end
  end

  always @(negedge clk) begin
    if (m0_wr) wr_obs.push_back({m0_addr, m0_dout});
    if (rd_valid) rd_obs.push_back(rd_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d);
    int   n;
    logic acc;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      n++;
    end while (!acc && n < 2000);
    cmd_valid = 1'b0;
    if (!acc) check_eq("push_accept", 0, 1);
  endtask

  task automatic wait_err(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!err && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    check_eq(tag, err, 1);
  endtask

  task automatic pulse_clr();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  logic [31:0] ref_mem [16];
  logic [47:0] wr_exp [$];
  logic [31:0] rd_exp [$];

  initial begin
    int          cnt, first, gaps, wr_at;
    logic        cr1, cr2, bsy4;
    logic [47:0] burst [9];
    logic [2:0]  op;
    logic [15:0] a;
    logic [31:0] d;
    int          dly [3];

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    d_interrupt = 1'b0; a_interrupt = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_m0_req", m0_req, 0);
    check_eq("rst_m0_wr", m0_wr, 0);
    check_eq("rst_m0_addr", m0_addr, 16'hFFFF);
    check_eq("rst_m0_dout", m0_dout, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    step();
    reset = 1'b0;
    grant_dir = 1'b1;
    repeat (2) step();

    // WRITE with grant high: pop, REQ, one WR cycle, back to idle bus
    push(3'd0, 16'h0003, 32'h0000_0300);
    @(negedge clk);
    check_eq("wr_pop_req", m0_req, 0);
    check_eq("wr_pop_busy", busy, 1);
    step(); @(negedge clk);
    check_eq("wr_req", m0_req, 1);
    check_eq("wr_req_wr", m0_wr, 0);
    check_eq("wr_req_addr", m0_addr, 16'h0003);
    step(); @(negedge clk);
    check_eq("wr_strobe", m0_wr, 1);
    check_eq("wr_addr", m0_addr, 16'h0003);
    check_eq("wr_dout", m0_dout, 32'h0000_0300);
    step(); @(negedge clk);
    check_eq("wr_done_wr", m0_wr, 0);
    check_eq("wr_done_req", m0_req, 0);
    check_eq("wr_done_addr", m0_addr, 16'hFFFF);
    check_eq("wr_done_busy", busy, 0);
    step();

    // READ of address 5 (slave holds 1 there)
    push(3'd1, 16'h0005, 32'h0);
    repeat (2) step();
    @(negedge clk);
    check_eq("rd_pre_valid", rd_valid, 0);
    step(); @(negedge clk);
    check_eq("rd_valid", rd_valid, 1);
    check_eq("rd_data", rd_data, 32'h1);
    step(); @(negedge clk);
    check_eq("rd_pulse_end", rd_valid, 0);
    step();

    // Reset in the middle of a WRITE with another command queued
    push(3'd0, 16'h0007, 32'h77);
    push(3'd0, 16'h0008, 32'h88);
    cnt = 0;
    @(negedge clk);
    while (!m0_wr && cnt < 20) begin step(); @(negedge clk); cnt++; end
    check_eq("rst_mid_saw_wr", m0_wr, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_mid_wr", m0_wr, 0);
    check_eq("rst_mid_addr", m0_addr, 16'hFFFF);
    check_eq("rst_mid_ready", cmd_ready, 1);
    check_eq("rst_mid_busy", busy, 0);
    step();
    reset = 1'b0;
    wr_obs.delete();
    repeat (10) step();
    check_eq("rst_mid_flushed", wr_obs.size(), 0);

    // WRITE, WAIT_DIRQ, clearing WRITE
    push(3'd0, 16'h0000, 32'h1);
    push(3'd2, 16'h0000, 32'h0);
    push(3'd0, 16'h0001, 32'h0);
    cnt = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j >= 4 && m0_req) cnt++;
      step();
    end
    check_eq("irq_wait_req", cnt, 0);
    check_eq("irq_wait_busy", busy, 1);
    d_interrupt = 1'b1;
    wr_at = -1;
    bsy4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (m0_wr && wr_at < 0) wr_at = k;
      if (k == 3) check_eq("irq_clr_addr", m0_addr, 16'h0001);
      if (k == 4) bsy4 = busy;
      step();
    end
    check_eq("irq_clr_cycle", wr_at, 3);
    check_eq("irq_busy_drop", bsy4, 0);
    d_interrupt = 1'b0;

    // DELAY durations: busy spans the pop cycle plus max(n,1) cycles
    dly[0] = 0; dly[1] = 1; dly[2] = 5;
    for (int i = 0; i < 3; i++) begin
      push(3'd4, 16'h0, 32'(dly[i]));
      cnt = 0;
      @(negedge clk);
      while (busy && cnt < 50) begin cnt++; step(); @(negedge clk); end
      check_eq($sformatf("delay_%0d", dly[i]), cnt, 1 + ((dly[i] == 0) ? 1 : dly[i]));
      step();
    end

    // Grant timeout, then recovery via err_clr
    grant_dir = 1'b0;
    step();
    push(3'd0, 16'h0009, 32'h99);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (err) break;
      if (m0_req) cnt++;
      step();
    end
    check_eq("to_err", err, 1);
    check_eq("to_req_cycles", cnt, TO);
    check_eq("to_code", err_code, 2'b01);
    check_eq("to_req_low", m0_req, 0);
    step();
    grant_dir = 1'b1;
    wr_obs.delete();
    push(3'd0, 16'h000A, 32'hAAAA);
    repeat (5) step();
    @(negedge clk);
    check_eq("err_hold_nowr", wr_obs.size(), 0);
    check_eq("err_hold_busy", busy, 1);
    check_eq("err_hold_err", err, 1);
    pulse_clr();
    @(negedge clk);
    check_eq("err_clr_err", err, 0);
    check_eq("err_clr_code", err_code, 0);
    cnt = 0;
    while (wr_obs.size() < 1 && cnt < 20) begin step(); cnt++; end
    check_eq("err_next_cmd", (wr_obs.size() > 0) ? wr_obs[0] : 48'h0, {16'h000A, 32'hAAAA});
    step();

    // Reserved opcode
    push(3'd6, 16'h0, 32'h0);
    wait_err("rsv_err");
    check_eq("rsv_code", err_code, 2'b11);
    pulse_clr();
    @(negedge clk);
    check_eq("rsv_clr_err", err, 0);
    check_eq("rsv_clr_busy", busy, 0);
    step();

    // Full FIFO with grant held low, then release
    grant_dir = 1'b0;
    step();
    wr_obs.delete();
    for (int i = 0; i < 9; i++) begin
      burst[i] = {16'h0100 + 16'(i), $urandom()};
      push(3'd0, burst[i][47:32], burst[i][31:0]);
    end
    @(negedge clk);
    check_eq("full_ready", cmd_ready, 0);
    check_eq("full_nowr", wr_obs.size(), 0);
    grant_dir = 1'b1;
    first = -1; gaps = 0; cr1 = 1'bx; cr2 = 1'bx;
    for (int k = 0; k < 100 && wr_obs.size() < 9; k++) begin
      @(negedge clk);
      if (first < 0 && m0_wr) first = k;
      if (first >= 0 && k == first + 1) cr1 = cmd_ready;
      if (first >= 0 && k == first + 2) cr2 = cmd_ready;
      if (first >= 0 && !m0_req) gaps++;
      step();
    end
    check_eq("full_pop_cycle_ready", cr1, 0);
    check_eq("full_after_pop_ready", cr2, 1);
    check_eq("full_req_gaps", gaps, 0);
    check_eq("full_wr_count", wr_obs.size(), 9);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("full_wr_%0d", i), (i < wr_obs.size()) ? wr_obs[i] : 48'h0, burst[i]);
    repeat (3) step();

    // Randomized stream against a memory model
    wr_obs.delete(); rd_obs.delete(); wr_exp.delete(); rd_exp.delete();
    rand_grant = 1'b1;
    a_interrupt = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom_range(0, 4095) % 4096, 4'(i)};
      d = $urandom();
      ref_mem[i] = d;
      wr_exp.push_back({a, d});
      push(3'd0, a, d);
    end
    for (int i = 0; i < 80; i++) begin
      cnt = $urandom_range(0, 99);
      op = (cnt < 45) ? 3'd0 : (cnt < 85) ? 3'd1 : (cnt < 93) ? 3'd4 : 3'd3;
      a = 16'($urandom());
      d = (op == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom();
      if (op == 3'd0) begin
        ref_mem[a[3:0]] = d;
        wr_exp.push_back({a, d});
      end else if (op == 3'd1) begin
        rd_exp.push_back(ref_mem[a[3:0]]);
      end
      push(op, a, d);
    end
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 5000) begin step(); @(negedge clk); cnt++; end
    check_eq("rand_drain", busy, 0);
    repeat (3) step();
    check_eq("rand_err", err, 0);
    check_eq("rand_wr_count", wr_obs.size(), wr_exp.size());
    check_eq("rand_rd_count", rd_obs.size(), rd_exp.size());
    for (int i = 0; i < wr_exp.size(); i++)
      check_eq($sformatf("rand_wr_%0d", i), (i < wr_obs.size()) ? wr_obs[i] : 48'h0, wr_exp[i]);
    for (int i = 0; i < rd_exp.size(); i++)
      check_eq($sformatf("rand_rd_%0d", i), (i < rd_obs.size()) ? rd_obs[i] : 32'h0, rd_exp[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
